rv_decode_ctrl: RTL



---
 rtl/rv_ctrl_pkg.sv | 36 +++
 rtl/rv_decode_ctrl_alu_op_decode.sv | 61 ++++++
 rtl/rv_decode_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared constants for the RV64 decode/control stage.
// ALU op codes, opcode/funct fields and FSM state encoding.
package rv_ctrl_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_MUL = 4'b0110;
  localparam logic [3:0] ALU_XOR = 4'b0111;
  localparam logic [3:0] ALU_HCF = 4'b1001;

  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SRL = 3'b101;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DECODE  = 3'd1,
    ISSUE   = 3'd2,
    WAIT_MC = 3'd3,
    WB      = 3'd4,
    ERR     = 3'd5
  } ctrl_state_t;

endpackage

// File: rtl/rv_decode_ctrl_alu_op_decode.sv
// Combinational ALU-op decode: instr -> alu_control, is_mc, legal.
// Only opcode, funct3 and funct7 take part; register fields pass by.
module rv_alu_op_decode
  import rv_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output logic [3:0]  alu_control,
  output logic        is_mc,
  output logic        legal
);

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;
  logic       is_base;
  logic       is_mul;
  logic       is_hcf;
  logic       unused_fields;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign unused_fields = ^{instr[24:15], instr[11:7]};

  assign is_base = (opcode == OPC_OP) && (funct7 == F7_BASE);
  assign is_mul  = (opcode == OPC_OP) && (funct7 == F7_MULDIV)
                && (funct3 == F3_ADD);
  assign is_hcf  = (opcode == OPC_CUSTOM0) && (funct7 == F7_BASE)
                && (funct3 == F3_ADD);

  always_comb begin
    alu_control = ALU_AND;
    is_mc       = 1'b0;
    legal       = 1'b0;
    unique case (1'b1)
      is_base: begin
        legal = 1'b1;
        case (funct3)
          F3_ADD:  alu_control = ALU_ADD;
          F3_SLL:  alu_control = ALU_SLL;
          F3_XOR:  alu_control = ALU_XOR;
          F3_SRL:  alu_control = ALU_SRL;
          F3_OR:   alu_control = ALU_OR;
          F3_AND:  alu_control = ALU_AND;
          default: legal = 1'b0;
        endcase
      end
      is_mul: begin
        legal       = 1'b1;
        alu_control = ALU_MUL;
      end
      is_hcf: begin
        legal       = 1'b1;
        is_mc       = 1'b1;
        alu_control = ALU_HCF;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rv_decode_ctrl.sv
// Decode/control stage ahead of the regfile/ALU datapath.
// Optional RAW_INTERLOCK_EN adds a one-cycle DECODE bubble on RAW hazards.
module rv_decode_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int MC_TIMEOUT = 64,
  parameter int CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  output logic [4:0]       read_reg_num1,
  output logic [4:0]       read_reg_num2,
  output logic [4:0]       write_reg,
  output logic [3:0]       alu_control,
  output logic             regwrite,
  output logic             mc_start,
  input  logic             mc_done,
  output logic             illegal,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam int TW = $clog2(MC_TIMEOUT + 1);

  ctrl_state_t state;
  logic [31:0] instr_q;
  logic [TW-1:0] timer;
  logic [3:0] dec_alu;
  logic dec_mc;
  logic dec_legal;
  logic stall;

  rv_alu_op_decode u_dec (
    .instr       (instr_q),
    .alu_control (dec_alu),
    .is_mc       (dec_mc),
    .legal       (dec_legal)
  );

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

`ifdef RAW_INTERLOCK_EN
  logic [4:0] last_rd;
  logic bubble_q;
  logic hazard;

  assign hazard = (last_rd != 5'd0)
               && ((read_reg_num1 == last_rd)
                || (read_reg_num2 == last_rd));
  assign stall = hazard && !bubble_q;

  // One bubble per instruction; cleared once DECODE moves on.
  always_ff @(posedge clock) begin
    if (!reset) begin
      last_rd  <= 5'd0;
      bubble_q <= 1'b0;
    end else begin
      if (state == DECODE)
        bubble_q <= stall;
      if ((state == ISSUE && !mc_start) || state == WB)
        last_rd <= write_reg;
    end
  end
`else
  assign stall = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      state         <= IDLE;
      instr_q       <= 32'd0;
      timer         <= '0;
      in_ready      <= 1'b0;
      read_reg_num1 <= 5'd0;
      read_reg_num2 <= 5'd0;
      write_reg     <= 5'd0;
      alu_control   <= ALU_AND;
      regwrite      <= 1'b0;
      mc_start      <= 1'b0;
      illegal       <= 1'b0;
      retired_cnt   <= '0;
      illegal_cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            instr_q       <= in_instr;
            read_reg_num1 <= in_instr[19:15];
            read_reg_num2 <= in_instr[24:20];
            write_reg     <= in_instr[11:7];
            in_ready      <= 1'b0;
            state         <= DECODE;
          end
        end
        DECODE: begin
          if (!stall) begin
            if (!dec_legal) begin
              illegal <= 1'b1;
              state   <= ERR;
            end else begin
              alu_control <= dec_alu;
              state       <= ISSUE;
              if (dec_mc)
                mc_start <= 1'b1;
              else
                regwrite <= (write_reg != 5'd0);
            end
          end
        end
        ISSUE: begin
          // mc_start still high here marks the HCF path.
          if (mc_start) begin
            mc_start <= 1'b0;
            timer    <= '0;
            state    <= WAIT_MC;
          end else begin
            regwrite    <= 1'b0;
            retired_cnt <= sat_inc(retired_cnt);
            in_ready    <= 1'b1;
            state       <= IDLE;
          end
        end
        WAIT_MC: begin
          if (mc_done) begin
            regwrite <= (write_reg != 5'd0);
            state    <= WB;
          end else if (timer == TW'(MC_TIMEOUT - 1)) begin
            illegal <= 1'b1;
            state   <= ERR;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        WB: begin
          regwrite    <= 1'b0;
          retired_cnt <= sat_inc(retired_cnt);
          in_ready    <= 1'b1;
          state       <= IDLE;
        end
        ERR: begin
          illegal     <= 1'b0;
          illegal_cnt <= sat_inc(illegal_cnt);
          in_ready    <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
